cpu_core_gen2: RTL and testbench

Parametrised multi-cycle accumulator CPU core: the next-generation replacement for the fixed 8-bit microcoded core, with generic data/address width, an N-entry register file, a wait-stated memory bus (`mem_ready`), and a handshaked output port. It is a hardwired-FSM sequencer and sits between the top-level memory map (RAM/ROM decode) and the output display register.

---
 rtl/cpu_core_gen2_if.sv | 26 ++
 rtl/cpu_core_gen2.sv | 195 +++++++++++++++++++
 tb/tb_cpu_core_gen2.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_gen2_if.sv
// Memory bus and output-port bundle of the accumulator core.
// The core drives the master side; memory/display logic sits on the slave side.
interface cpu_core_gen2_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output mem_address, mem_read, mem_write, mem_data_out, out_data, out_valid,
      input  mem_data_in, mem_ready, out_ready
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_data_out, out_data, out_valid,
      output mem_data_in, mem_ready, out_ready
   );
endinterface

// File: rtl/cpu_core_gen2.sv
// Multi-cycle accumulator CPU: hardwired FSM sequencer with wait-stated bus and handshaked output port.
//   state      | meaning
//   S_RESET    | one idle cycle after reset, no strobes
//   S_FETCH    | read opcode at PC
//   S_EXEC     | decode, ALU/MOV commit
//   S_IMM      | read immediate, LDI commit
//   S_ADDR_HI  | read high address word
//   S_ADDR_LO  | read low address word, resolve jumps
//   S_MEM_RD   | LDA data read and commit
//   S_MEM_WR   | STA data write
//   S_OUT_WAIT | out_valid held until out_ready
//   S_HALT     | terminal until reset
module cpu_core_gen2 #(
   parameter int          DATA_WIDTH   = 8,
   parameter int          ADDR_WIDTH   = 16,
   parameter int          NUM_REGS     = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_F000
) (
   input  logic                  clk,
   input  logic                  reset,
   cpu_core_gen2_if.master       bus,
   output logic                  halt,
   output logic                  flag_zero_o,
   output logic                  flag_carry_o,
   output logic                  flag_negative_o,
   output logic [ADDR_WIDTH-1:0] debug_pc,
   output logic [DATA_WIDTH-1:0] debug_ir
);
   localparam int RW = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] PC_RST = RESET_VECTOR[ADDR_WIDTH-1:0];

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_EXEC, S_IMM, S_ADDR_HI, S_ADDR_LO,
      S_MEM_RD, S_MEM_WR, S_OUT_WAIT, S_HALT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0] addr_hi_q, addr_hi_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  z_q, z_d, c_q, c_d, n_q, n_d;

   logic [3:0]            op;
   logic [RW-1:0]         rd;
   logic [DATA_WIDTH-1:0] r0, rd_val, alu_res;
   logic [DATA_WIDTH:0]   sum, diff;
   logic                  alu_c, jump_taken;
   logic [ADDR_WIDTH-1:0] target;

   assign op     = ir_q[7:4];
   assign rd     = ir_q[RW-1:0];
   assign r0     = regs_q[0];
   assign rd_val = regs_q[rd];
   assign sum    = {1'b0, r0} + {1'b0, rd_val};
   assign diff   = {1'b0, r0} - {1'b0, rd_val};
   assign target = ADDR_WIDTH'({addr_hi_q, bus.mem_data_in});

   always_comb begin
      alu_res = r0;
      alu_c   = 1'b0;
      case (op)
         4'h4:    {alu_c, alu_res} = sum;
         4'h5:    begin alu_res = diff[DATA_WIDTH-1:0]; alu_c = ~diff[DATA_WIDTH]; end
         4'h6:    alu_res = r0 & rd_val;
         4'h7:    alu_res = r0 | rd_val;
         4'h8:    alu_res = r0 ^ rd_val;
         default: ;
      endcase
   end

   always_comb begin
      case (op)
         4'hA:    jump_taken = 1'b1;
         4'hB:    jump_taken = z_q;
         4'hC:    jump_taken = c_q;
         4'hD:    jump_taken = n_q;
         default: jump_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RESET;
         pc_q       <= PC_RST;
         addr_q     <= '0;
         ir_q       <= '0;
         addr_hi_q  <= '0;
         out_data_q <= '0;
         regs_q     <= '{default: '0};
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         n_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         ir_q       <= ir_d;
         addr_hi_q  <= addr_hi_d;
         out_data_q <= out_data_d;
         regs_q     <= regs_d;
         z_q        <= z_d;
         c_q        <= c_d;
         n_q        <= n_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      ir_d       = ir_q;
      addr_hi_d  = addr_hi_q;
      out_data_d = out_data_q;
      regs_d     = regs_q;
      z_d        = z_q;
      c_d        = c_q;
      n_d        = n_q;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: if (bus.mem_ready) begin
            ir_d    = bus.mem_data_in;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op)
               4'h1: state_d = S_IMM;
               4'h2, 4'h3, 4'hA, 4'hB, 4'hC, 4'hD: state_d = S_ADDR_HI;
               4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                  regs_d[0] = alu_res;
                  z_d       = (alu_res == '0);
                  c_d       = alu_c;
                  n_d       = alu_res[DATA_WIDTH-1];
               end
               4'h9: regs_d[rd] = r0;
               4'hE: begin
                  out_data_d = rd_val;
                  state_d    = S_OUT_WAIT;
               end
               4'hF: state_d = S_HALT;
               default: ;
            endcase
         end
         S_IMM: if (bus.mem_ready) begin
            regs_d[rd] = bus.mem_data_in;
            z_d        = (bus.mem_data_in == '0);
            c_d        = 1'b0;
            n_d        = bus.mem_data_in[DATA_WIDTH-1];
            pc_d       = pc_q + ADDR_WIDTH'(1);
            state_d    = S_FETCH;
         end
         S_ADDR_HI: if (bus.mem_ready) begin
            addr_hi_d = bus.mem_data_in;
            pc_d      = pc_q + ADDR_WIDTH'(1);
            state_d   = S_ADDR_LO;
         end
         S_ADDR_LO: if (bus.mem_ready) begin
            addr_d  = target;
            pc_d    = jump_taken ? target : pc_q + ADDR_WIDTH'(1);
            state_d = (op == 4'h2) ? S_MEM_RD : (op == 4'h3) ? S_MEM_WR : S_FETCH;
         end
         S_MEM_RD: if (bus.mem_ready) begin
            regs_d[rd] = bus.mem_data_in;
            z_d        = (bus.mem_data_in == '0);
            c_d        = 1'b0;
            n_d        = bus.mem_data_in[DATA_WIDTH-1];
            state_d    = S_FETCH;
         end
         S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
         S_OUT_WAIT: if (bus.out_ready) state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_RESET;
      endcase
   end

   // Strobes decode from state only, so ready inputs never reach them combinationally.
   assign bus.mem_read     = (state_q == S_FETCH) || (state_q == S_IMM) || (state_q == S_ADDR_HI) ||
                             (state_q == S_ADDR_LO) || (state_q == S_MEM_RD);
   assign bus.mem_write    = (state_q == S_MEM_WR);
   assign bus.mem_address  = ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) ? addr_q : pc_q;
   assign bus.mem_data_out = (state_q == S_MEM_WR) ? rd_val : '0;
   assign bus.out_valid    = (state_q == S_OUT_WAIT);
   assign bus.out_data     = out_data_q;
   assign halt             = (state_q == S_HALT);
   assign flag_zero_o      = z_q;
   assign flag_carry_o     = c_q;
   assign flag_negative_o  = n_q;
   assign debug_pc         = pc_q;
   assign debug_ir         = ir_q;
endmodule

// File: tb/tb_cpu_core_gen2.sv
// Bench for cpu_core_gen2: 8-bit and 12-bit/8-register instances, output and write scoreboards.
module tb_cpu_core_gen2;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst8 = 1'b1, rst12 = 1'b1;
   int   wait_n8 = 0, owait_n8 = 0;
   int   wcnt8 = 0, ocnt8 = 0, wr_acc8 = 0;
   int   n_checks = 0, n_errors = 0;

   logic [31:0] q8[$], q12[$], qwr[$];
   logic [7:0]  mem8  [65536];
   logic [11:0] mem12 [65536];

   cpu_core_gen2_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(16)) b8 ();
   cpu_core_gen2_if #(.DATA_WIDTH(12), .ADDR_WIDTH(16)) b12 ();

   logic        halt8, z8, c8, n8, halt12, z12, c12, n12;
   logic [15:0] pc8, pc12;
   logic [7:0]  ir8;
   logic [11:0] ir12;

   cpu_core_gen2 dut8 (
      .clk(clk), .reset(rst8), .bus(b8), .halt(halt8),
      .flag_zero_o(z8), .flag_carry_o(c8), .flag_negative_o(n8),
      .debug_pc(pc8), .debug_ir(ir8)
   );

   cpu_core_gen2 #(.DATA_WIDTH(12), .NUM_REGS(8)) dut12 (
      .clk(clk), .reset(rst12), .bus(b12), .halt(halt12),
      .flag_zero_o(z12), .flag_carry_o(c12), .flag_negative_o(n12),
      .debug_pc(pc12), .debug_ir(ir12)
   );

   // Memory and display models: requests wait wait_n8 / owait_n8 cycles before acceptance.
   assign b8.mem_data_in  = mem8[b8.mem_address];
   assign b8.mem_ready    = (b8.mem_read | b8.mem_write) && (wcnt8 == wait_n8);
   assign b8.out_ready    = b8.out_valid && (ocnt8 == owait_n8);
   assign b12.mem_data_in = mem12[b12.mem_address];
   assign b12.mem_ready   = b12.mem_read | b12.mem_write;
   assign b12.out_ready   = 1'b1;

   always @(posedge clk) begin
      if (rst8 || !(b8.mem_read | b8.mem_write) || b8.mem_ready) wcnt8 <= 0;
      else wcnt8 <= wcnt8 + 1;
      if (rst8 || !b8.out_valid || b8.out_ready) ocnt8 <= 0;
      else ocnt8 <= ocnt8 + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ent(input logic z, input logic c, input logic n, input logic [11:0] d);
      return {17'd0, z, c, n, d};
   endfunction

   always @(negedge clk) begin
      logic [31:0] exp_v;
      if (b8.out_valid && b8.out_ready) begin
         if (q8.size() > 0) exp_v = q8.pop_front(); else exp_v = 32'hDEAD_0000;
         check_val("out8", ent(z8, c8, n8, {4'd0, b8.out_data}), exp_v);
      end
      if (b12.out_valid && b12.out_ready) begin
         if (q12.size() > 0) exp_v = q12.pop_front(); else exp_v = 32'hDEAD_0000;
         check_val("out12", ent(z12, c12, n12, b12.out_data), exp_v);
      end
      if (b8.mem_write && b8.mem_ready) begin
         wr_acc8++;
         if (qwr.size() > 0) exp_v = qwr.pop_front(); else exp_v = 32'hFFFF_FFFF;
         check_val("wr8", {8'd0, b8.mem_address, b8.mem_data_out}, exp_v);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset8_seq;
      rst8 = 1'b1;
      tick();
      tick();
      rst8 = 1'b0;
   endtask

   task automatic run_halt8(input int max);
      for (int i = 0; i < max && !halt8; i++) tick();
      check_val("halt8_reached", {31'd0, halt8}, 32'd1);
   endtask

   task automatic load8(input logic [15:0] base, input int n, input logic [127:0] img);
      for (int i = 0; i < n; i++) mem8[16'(base + i)] = img[8*(n-1-i) +: 8];
   endtask

   task automatic load12(input logic [15:0] base, input int n, input logic [191:0] img);
      for (int i = 0; i < n; i++) mem12[16'(base + i)] = img[12*(n-1-i) +: 12];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_cnt, wcyc, bad, t_sta, t_nxt, vcnt;
      for (int i = 0; i < 65536; i++) begin
         mem8[i]  = 8'h00;
         mem12[i] = 12'h000;
      end

      // LDI R0,#05 ; HLT
      load8(16'hF000, 3, 128'h10_05_F0);
      reset8_seq();
      check_val("rst_strobes", {1'b0, b8.mem_read, b8.mem_write, b8.out_valid, halt8, z8, c8, n8,
                                b8.mem_data_out, b8.out_data, ir8}, 32'd0);
      check_val("rst_pc", {16'd0, pc8}, 32'h0000_F000);
      tick();
      check_val("first_req", {15'd0, b8.mem_read, b8.mem_address}, {15'd0, 1'b1, 16'hF000});
      repeat (4) tick();
      check_val("halt_c5", {31'd0, halt8}, 32'd0);
      tick();
      check_val("halt_c6", {31'd0, halt8}, 32'd1);
      check_val("r0_ldi", {24'd0, dut8.regs_q[0]}, 32'h05);
      check_val("zn_ldi", {30'd0, z8, n8}, 32'd0);
      rd_cnt = 0;
      repeat (4) begin
         tick();
         rd_cnt += int'(b8.mem_read);
      end
      check_val("halt_no_read", rd_cnt, 0);
      check_val("halt_pc", {16'd0, pc8}, 32'h0000_F003);

      // LDI R0,#FF ; LDI R1,#01 ; ADD R1 ; OUT R0 ; SUB R1 ; OUT R0 ; HLT
      load8(16'hF000, 9, 128'h10_FF_11_01_41_E0_51_E0_F0);
      q8.push_back(ent(1'b1, 1'b1, 1'b0, 12'h000));
      q8.push_back(ent(1'b0, 1'b0, 1'b1, 12'h0FF));
      reset8_seq();
      run_halt8(100);
      check_val("alu_sb_drain", q8.size(), 0);
      check_val("sub_flags", {29'd0, z8, c8, n8}, 32'b001);

      // LDI R2,#3C ; STA R2,[8000] ; HLT with two wait cycles per request
      wait_n8 = 2;
      load8(16'hF000, 6, 128'h12_3C_32_80_00_F0);
      qwr.push_back({8'd0, 16'h8000, 8'h3C});
      wr_acc8 = 0;
      reset8_seq();
      wcyc = 0; bad = 0; t_sta = -1; t_nxt = -1;
      for (int cyc = 0; cyc < 100 && !halt8; cyc++) begin
         if (b8.mem_write) begin
            wcyc++;
            if (b8.mem_address != 16'h8000 || b8.mem_data_out != 8'h3C) bad++;
         end
         if (b8.mem_read && b8.mem_address == 16'hF002 && t_sta < 0) t_sta = cyc;
         if (b8.mem_read && b8.mem_address == 16'hF005 && t_nxt < 0) t_nxt = cyc;
         tick();
      end
      check_val("sta_wr_cycles", wcyc, 3);
      check_val("sta_wr_bus", bad, 0);
      check_val("sta_wr_accepts", wr_acc8, 1);
      check_val("sta_cycles", t_nxt - t_sta, 13);
      check_val("sta_sb_drain", qwr.size(), 0);

      // Jump chain: JZ/JC/JN each not taken then taken; wrong paths halt at other PCs
      wait_n8 = 0;
      load8(16'hF000, 3,  128'hA0_00_10);
      load8(16'h0010, 10, 128'hB0_00_40_10_00_E0_B0_00_20_F0);
      load8(16'h0020, 12, 128'hC0_00_50_10_FF_11_01_41_C0_00_30_F0);
      load8(16'h0030, 10, 128'hD0_00_60_10_80_D0_00_38_E0_F0);
      load8(16'h0040, 1, 128'hF0);
      load8(16'h0050, 1, 128'hF0);
      load8(16'h0060, 1, 128'hF0);
      q8.push_back(ent(1'b1, 1'b0, 1'b0, 12'h000));
      q8.push_back(ent(1'b0, 1'b0, 1'b1, 12'h080));
      reset8_seq();
      repeat (5) tick();
      check_val("jmp_fetch", {15'd0, b8.mem_read, b8.mem_address}, {15'd0, 1'b1, 16'h0010});
      repeat (4) tick();
      check_val("jz_nt_fetch", {15'd0, b8.mem_read, b8.mem_address}, {15'd0, 1'b1, 16'h0013});
      run_halt8(200);
      check_val("jmp_end_pc", {16'd0, pc8}, 32'h0000_003A);
      check_val("jmp_sb_drain", q8.size(), 0);

      // LDI R3,#A5 ; OUT R3 ; HLT with out_ready held off for 4 cycles
      owait_n8 = 4;
      load8(16'hF000, 4, 128'h13_A5_E3_F0);
      q8.push_back(ent(1'b0, 1'b0, 1'b1, 12'h0A5));
      reset8_seq();
      for (int i = 0; i < 50 && !b8.out_valid; i++) tick();
      vcnt = 0; bad = 0;
      for (int i = 0; i < 50 && b8.out_valid; i++) begin
         vcnt++;
         if (b8.out_data != 8'hA5) bad++;
         tick();
      end
      check_val("out_valid_cycles", vcnt, 5);
      check_val("out_data_held", bad, 0);
      check_val("out_resume", {15'd0, b8.mem_read, b8.mem_address}, {15'd0, 1'b1, 16'hF003});
      check_val("out_data_after", {24'd0, b8.out_data}, 32'h0A5);
      run_halt8(50);
      check_val("out_sb_drain", q8.size(), 0);

      // Reset during a stalled STA write
      owait_n8 = 0;
      wait_n8  = 2;
      load8(16'hF000, 6, 128'h12_BC_32_80_00_F0);
      reset8_seq();
      for (int i = 0; i < 80 && !b8.mem_write; i++) tick();
      check_val("abort_wr_seen", {31'd0, b8.mem_write}, 32'd1);
      rst8 = 1'b1;
      tick();
      check_val("abort_strobes", {20'd0, b8.mem_write, b8.mem_read, b8.out_valid, halt8, z8, c8, n8,
                                  b8.out_data, 1'b0}, 32'd0);
      check_val("abort_pc", {16'd0, pc8}, 32'h0000_F000);
      check_val("abort_r2", {24'd0, dut8.regs_q[2]}, 32'd0);

      // 12-bit core: LDI R0,#FFF ; LDI R7,#1 ; ADD R7 ; OUT R0 ; SUB R7 ; OUT R0 ; MOV R7 ; OUT R7 ; HLT
      load12(16'hF000, 11, 192'h310_FFF_017_001_047_0E0_057_0E0_097_0E7_0F0);
      q12.push_back(ent(1'b1, 1'b1, 1'b0, 12'h000));
      q12.push_back(ent(1'b0, 1'b0, 1'b1, 12'hFFF));
      q12.push_back(ent(1'b0, 1'b0, 1'b1, 12'hFFF));
      tick();
      tick();
      rst12 = 1'b0;
      for (int i = 0; i < 200 && !halt12; i++) tick();
      check_val("halt12_reached", {31'd0, halt12}, 32'd1);
      check_val("w12_sb_drain", q12.size(), 0);
      check_val("w12_end_pc", {16'd0, pc12}, 32'h0000_F00B);
      check_val("w12_flags", {29'd0, z12, c12, n12}, 32'b001);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
